// File: rtl/video_timing_gen_if.sv
// Video timing output bundle: sync, data enable, pixel position
// and run status, driven by the generator and read by sinks.
interface video_timing_gen_if;
   logic        hs;
   logic        vs;
   logic        de;
   logic [11:0] x_pos;
   logic [11:0] y_pos;
   logic        frame_start;
   logic        timing_valid;

   modport master (
      output hs, vs, de, x_pos, y_pos,
      output frame_start, timing_valid
   );

   modport slave (
      input hs, vs, de, x_pos, y_pos,
      input frame_start, timing_valid
   );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: qualifies PLL lock, then emits registered
// hs/vs/de, pixel coordinates and a frame-start pulse.
module video_timing_gen #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1,
   parameter int LOCK_CNT = 1024
) (
   input  logic               pix_clk,
   input  logic               rst_n,
   input  logic               pll_lock,
   input  logic               enable,
   video_timing_gen_if.master vid
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int LW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

   localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
   localparam logic [12:0] H_ACT  = 13'(H_ACTIVE);
   localparam logic [12:0] V_ACT  = 13'(V_ACTIVE);
   localparam logic [12:0] HS_ON  = 13'(H_ACTIVE + H_FP);
   localparam logic [12:0] HS_OFF = 13'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [12:0] VS_ON  = 13'(V_ACTIVE + V_FP);
   localparam logic [12:0] VS_OFF = 13'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CNT - 1);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WAIT_LOCK = 2'd1;
   localparam logic [1:0] RUN       = 2'd2;

   if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
      $error("video_timing_gen: H_TOTAL/V_TOTAL exceed 12-bit counters");
   end

   if (LOCK_CNT < 1) begin : g_bad_lock
      $error("video_timing_gen: LOCK_CNT must be at least 1");
   end

   logic [1:0]    sync_q;
   logic          lock_s;
   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [LW-1:0] lock_cnt;
   logic [11:0]   h_cnt;
   logic [11:0]   v_cnt;
   logic          h_last;
   logic          v_last;
   logic          hs_act;
   logic          vs_act;
   logic          de_act;

   logic          hs_q;
   logic          vs_q;
   logic          de_q;
   logic          fs_q;
   logic          tv_q;
   logic [11:0]   x_q;
   logic [11:0]   y_q;

   assign lock_s = sync_q[1];
   assign h_last = (h_cnt == H_LAST);
   assign v_last = (v_cnt == V_LAST);

   assign hs_act = ({1'b0, h_cnt} >= HS_ON) && ({1'b0, h_cnt} < HS_OFF);
   assign vs_act = ({1'b0, v_cnt} >= VS_ON) && ({1'b0, v_cnt} < VS_OFF);
   assign de_act = ({1'b0, h_cnt} < H_ACT) && ({1'b0, v_cnt} < V_ACT);

   // Lock loss wins over the end-of-frame exit requested by enable.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (enable && lock_s)
               state_nxt = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (!enable)
               state_nxt = IDLE;
            else if (lock_s && lock_cnt == LOCK_LAST)
               state_nxt = RUN;
         end
         RUN: begin
            if (!lock_s)
               state_nxt = IDLE;
            else if (!enable && h_last && v_last)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         state    <= IDLE;
         lock_cnt <= '0;
         h_cnt    <= '0;
         v_cnt    <= '0;
      end else begin
         sync_q <= {sync_q[0], pll_lock};
         state  <= state_nxt;

         if (state == WAIT_LOCK && state_nxt == WAIT_LOCK && lock_s)
            lock_cnt <= lock_cnt + LW'(1);
         else
            lock_cnt <= '0;

         // Counters sit at 0 outside RUN, so entering RUN starts at (0,0).
         if (state != RUN) begin
            h_cnt <= '0;
            v_cnt <= '0;
         end else begin
            h_cnt <= h_last ? 12'd0 : h_cnt + 12'd1;
            if (h_last)
               v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
         end
      end
   end

   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_q <= ~HS_POL;
         vs_q <= ~VS_POL;
         de_q <= 1'b0;
         fs_q <= 1'b0;
         tv_q <= 1'b0;
         x_q  <= '0;
         y_q  <= '0;
      end else begin
         tv_q <= (state_nxt == RUN);
         if (state == RUN) begin
            hs_q <= hs_act ? HS_POL : ~HS_POL;
            vs_q <= vs_act ? VS_POL : ~VS_POL;
            de_q <= de_act;
            fs_q <= de_act && h_cnt == 12'd0 && v_cnt == 12'd0;
            x_q  <= de_act ? h_cnt : 12'd0;
            y_q  <= de_act ? v_cnt : 12'd0;
         end else begin
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
            de_q <= 1'b0;
            fs_q <= 1'b0;
            x_q  <= '0;
            y_q  <= '0;
         end
      end
   end

   assign vid.hs           = hs_q;
   assign vid.vs           = vs_q;
   assign vid.de           = de_q;
   assign vid.frame_start  = fs_q;
   assign vid.timing_valid = tv_q;
   assign vid.x_pos        = x_q;
   assign vid.y_pos        = y_q;

endmodule
